// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - timing constants and helpers shared by debounce_bank and debounce_channel
package debounce_pkg;

  localparam int CLK_HZ = 100000000;

  function automatic int ms_to_cycles(input int ms);
    return ms * (CLK_HZ / 1000);
  endfunction

  localparam int DEBOUNCE_CYCLES_DEF = ms_to_cycles(10);
  localparam int HOLD_CYCLES_DEF     = ms_to_cycles(500);
  localparam int REPEAT_CYCLES_DEF   = ms_to_cycles(100);

  // A flip needs at least two counted cycles so edge pulses can never be back to back.
  function automatic bit cfg_ok(input int deb, input int hold, input int rep);
    return (deb >= 2) && (hold >= 2) && (rep >= 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchroniser, debounce counter, edge pulses and optional auto-repeat
// Auto-repeat is built only when DEBOUNCE_REPEAT_EN is defined; otherwise rep is tied low.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic rep,
  output logic rise_set
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit CFG_OK = cfg_ok(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] cnt;
  logic             flip;
  logic             clean_next;

  assign flip       = (sync1 != clean) && (cnt == CNT_LAST);
  assign rise_set   = flip && sync1;
  assign clean_next = flip ? sync1 : clean;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync0 <= noisy;
      sync1 <= sync0;
      rise  <= flip && sync1;
      fall  <= flip && !sync1;
      if (sync1 == clean) begin
        cnt <= '0;
      end else if (flip) begin
        clean <= sync1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int HW = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);

  // hcnt first times the initial hold, then is reused for the repeat period once in_rep is set.
  logic [HW-1:0] hcnt;
  logic          in_rep;

  always_ff @(posedge clk) begin
    if (reset || !clean_next || rise_set) begin
      hcnt   <= '0;
      in_rep <= 1'b0;
      rep    <= 1'b0;
    end else if (!in_rep) begin
      if (hcnt == HW'(HOLD_CYCLES - 2)) begin
        hcnt   <= '0;
        in_rep <= 1'b1;
        rep    <= 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
        rep  <= 1'b0;
      end
    end else begin
      if (hcnt == HW'(REPEAT_CYCLES - 1)) begin
        hcnt <= '0;
        rep  <= 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
        rep  <= 1'b0;
      end
    end
  end
`else
  logic unused_clean_next;
  assign unused_clean_next = clean_next;
  assign rep = 1'b0 & ~CFG_OK;
`endif

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - N_CH independent debounced button/switch channels plus a shared any_rise pulse
// Define DEBOUNCE_REPEAT_EN to build the per-channel auto-repeat counters.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH            = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            any_rise,
  output logic [N_CH-1:0] repeat_pulse
);

  logic [N_CH-1:0] rise_set;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .noisy   (noisy_in[i]),
      .clean   (clean_out[i]),
      .rise    (rise_pulse[i]),
      .fall    (fall_pulse[i]),
      .rep     (repeat_pulse[i]),
      .rise_set(rise_set[i])
    );
  end

  // Built from the channels' next-cycle rise so it lands in the same cycle as rise_pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      any_rise <= 1'b0;
    end else begin
      any_rise <= |rise_set;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - scoreboard bench for debounce_bank with short debounce/hold/repeat periods
module tb_debounce_bank;

  localparam int N = 4;
  localparam int D = 8;
  localparam int H = 20;
  localparam int R = 6;

  typedef struct {
    int           cyc;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         any;
    logic [N-1:0] rep;
    logic [N-1:0] clean;
  } ev_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] noisy_in = '1;
  logic [N-1:0] clean_out;
  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;
  logic         any_rise;
  logic [N-1:0] repeat_pulse;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  ev_t  sb[$];
  logic [N-1:0] prev_clean = '0;

  debounce_bank #(
    .N_CH(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .reset(reset), .noisy_in(noisy_in), .clean_out(clean_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_rise(any_rise),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [N-1:0] r, input logic [N-1:0] f,
                      input logic [N-1:0] rp, input logic [N-1:0] cl);
    ev_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.any = |r; e.rep = rp; e.clean = cl;
    sb.push_back(e);
  endtask

  // Any pulse or level change is an output event that must match the oldest expectation.
  always @(negedge clk) begin
    ev_t e;
    if ((rise_pulse | fall_pulse | repeat_pulse) != '0 || any_rise !== 1'b0 ||
        clean_out !== prev_clean) begin
      check("event_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ev_cycle", 32'(cyc), 32'(e.cyc));
        check("ev_rise", 32'(rise_pulse), 32'(e.rise));
        check("ev_fall", 32'(fall_pulse), 32'(e.fall));
        check("ev_any_rise", 32'(any_rise), 32'(e.any));
        check("ev_repeat", 32'(repeat_pulse), 32'(e.rep));
        check("ev_clean", 32'(clean_out), 32'(e.clean));
      end
    end
    prev_clean = clean_out;
  end

  function automatic logic [31:0] outs();
    return 32'({clean_out, rise_pulse, fall_pulse, repeat_pulse, any_rise});
  endfunction

  initial begin
    int t;
    // reset with all inputs high, then a one-cycle high blip that must be filtered
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("reset_outputs", outs(), 32'd0);
    end
    reset = 1'b0;
    step(1);
    check("post_reset_outputs", outs(), 32'd0);
    noisy_in = '0;
    step(14);

    // channel 0 clean rise, held, then released
    t = cyc;
    noisy_in[0] = 1'b1;
    push(t + D + 2, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
`ifdef DEBOUNCE_REPEAT_EN
    for (int k = 0; k < 4; k++)
      push(t + D + 2 + H - 1 + k * R, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
`endif
    step(40);
    noisy_in[0] = 1'b0;
    push(t + 40 + D + 2, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(D + 15);

    // channel 1 bounces shorter than the debounce period
    noisy_in[1] = 1'b1; step(5);
    noisy_in[1] = 1'b0; step(1);
    noisy_in[1] = 1'b1; step(5);
    noisy_in[1] = 1'b0; step(D + 6);
    check("glitch_clean", 32'(clean_out), 32'd0);

    // channels 2 and 3 together
    t = cyc;
    noisy_in[3:2] = 2'b11;
    push(t + D + 2, 4'b1100, 4'b0000, 4'b0000, 4'b1100);
    step(12);
    noisy_in[3:2] = 2'b00;
    push(t + 12 + D + 2, 4'b0000, 4'b1100, 4'b0000, 4'b0000);
    step(D + 8);

    // reset while channel 0 count is at 5 discards the pending flip
    t = cyc;
    noisy_in[0] = 1'b1;
    step(7);
    reset = 1'b1;
    step(1);
    check("midcount_reset_outputs", outs(), 32'd0);
    step(1);
    check("midcount_reset_outputs2", outs(), 32'd0);
    reset = 1'b0;
    push(t + 9 + D + 2, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    step(12);
    noisy_in[0] = 1'b0;
    push(t + 21 + D + 2, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step(D + 10);

    check("queue_drained", 32'(sb.size()), 32'd0);
    check("final_clean", 32'(clean_out), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel successor to the single-input debouncer.
- Each channel synchronises an asynchronous pushbutton or switch and filters its bounce.
- Each channel produces a clean level plus single-cycle press and release pulses.
- Sits between the Nexys A7 button/switch pins and the game control FSM, so game logic consumes edge pulses directly instead of re-detecting edges.

Parameters:
- N_CH, 5, number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised input must differ stably from the clean level before the clean level flips (10 ms at 100 MHz); must be >=2.
- HOLD_CYCLES, 50000000, press duration before first auto-repeat pulse. Only used with the optional feature.
- REPEAT_CYCLES, 10000000, period between subsequent auto-repeat pulses. Only used with the optional feature.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- noisy_in  input  N_CH  raw asynchronous button/switch inputs.
- clean_out  output  N_CH  debounced level per channel.
- rise_pulse  output  N_CH  one-cycle pulse on each clean 0->1 transition.
- fall_pulse  output  N_CH  one-cycle pulse on each clean 1->0 transition.
- any_rise  output  1  OR of rise_pulse; one-cycle "any button pressed".
- repeat_pulse  output  N_CH  auto-repeat pulses; constant 0 when the feature is compiled out.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: sync stages 0, counters 0, clean_out 0, rise_pulse 0, fall_pulse 0, any_rise 0, repeat_pulse 0. Reset mid-count discards any pending transition.
- Synchroniser, per channel:
  - two flops, sync0 <= noisy_in[i], then sync1 <= sync0.
  - no logic between the two stages.
- Counter, per channel, width CNT_W = $clog2(DEBOUNCE_CYCLES), evaluated each clock:
  - sync1 == clean: cnt <= 0.
  - sync1 != clean and cnt == DEBOUNCE_CYCLES-1: clean <= sync1, cnt <= 0.
  - otherwise: cnt <= cnt+1.
- Latency: if sync0 first captures a new stable value at edge 0, clean_out changes at edge DEBOUNCE_CYCLES+1.
- Glitch rejection: any return of sync1 to the clean level before the count completes clears cnt; no output change. Pulses shorter than DEBOUNCE_CYCLES cycles never propagate.
- Edge pulses:
  - Registered, so rise_pulse/fall_pulse are high exactly in the first cycle in which clean_out shows the new level.
  - Low otherwise; never two consecutive cycles.
- any_rise is registered together with rise_pulse (same cycle).
- Channels are fully independent; simultaneous transitions on several channels each produce their own pulses in the same cycle.
- No saturation issues: cnt never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: DEBOUNCE_REPEAT_EN.
- Defined, per channel:
  - hold counter cleared on rise_pulse; increments while clean_out=1.
  - repeat_pulse fires one cycle when the counter reaches HOLD_CYCLES-1, then every REPEAT_CYCLES cycles while still held.
  - release (clean 0) or reset clears the counter and stops repeats immediately.
  - repeat_pulse never coincides with rise_pulse.
- Undefined: no hold counters are synthesised; repeat_pulse tied to 0.

Decomposition:
- Package debounce_pkg:
  - default constants DEBOUNCE_CYCLES_DEF = 1000000, HOLD_CYCLES_DEF, REPEAT_CYCLES_DEF.
  - CLK_HZ = 100000000.
  - a ms-to-cycles constant function.
- Sub-module debounce_channel (synchroniser, counter, edge pulses, optional repeat for one bit), instantiated N_CH times by a generate loop in debounce_bank. The top level adds only any_rise.

Test Plan (N_CH=4, DEBOUNCE_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=6):
- Reset held 3 cycles with noisy_in=4'hF -> all outputs 0 during reset and on the first cycle after release.
- noisy_in[0] 0->1 held stable (sync0 capture at edge 0) -> clean_out[0]=1 at edge 9; rise_pulse[0] and any_rise high for exactly that cycle.
- noisy_in[1] toggles high 5 cycles, low 1, high 5, then low -> clean_out[1] stays 0; no pulses.
- Channels 2 and 3 rise on the same cycle and stay high -> both rise_pulse bits high on one cycle; any_rise single pulse. Later release -> fall_pulse[2] and fall_pulse[3] each one cycle, 9 edges after capture.
- Reset asserted while channel 0 count is at 5 -> clean_out[0] stays 0; after release a full 8-cycle stable period is needed again.
- With DEBOUNCE_REPEAT_EN, channel 0 held 40 cycles after rise -> repeat_pulse[0] at hold counts 19, 25, 31, 37; none after release. Without the macro, repeat_pulse is always 0.
